// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: function codes,
// condition-code bit positions and the reset value of the condition codes.
package alu_arbiter_pkg;

  localparam logic [3:0] FUN_ADD = 4'd0;
  localparam logic [3:0] FUN_SUB = 4'd1;
  localparam logic [3:0] FUN_AND = 4'd2;
  localparam logic [3:0] FUN_XOR = 4'd3;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_INIT_DEFAULT = 3'b100;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_XOR
  } alu_op_e;

  // Unknown function codes fall back to add.
  function automatic alu_op_e decode_fun(input logic [3:0] fun);
    case (fun)
      FUN_SUB: return OP_SUB;
      FUN_AND: return OP_AND;
      FUN_XOR: return OP_XOR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer remembers the last winner and
// only moves when a grant is actually issued.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // last_q = 1 means requester 1 won last, so requester 0 wins the next tie.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (requester 0) and address
// generation (requester 1); a single result register feeds the consumer.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int         WIDTH   = 64,
  parameter logic [2:0] CC_INIT = CC_INIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [3:0]       r0_fun,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_setcc,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [3:0]       r1_fun,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_setcc,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_valE,
  output logic [2:0]       cc
);

  // Handshake: a request transfers on a clock edge where valid && ready are
  // both high; ready is combinational from valid, never the other way round.
  // The result transfers to the consumer where res_valid && res_ready.

  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] res_val_q, res_val_d;
  logic [2:0]       cc_q, cc_d;

  logic             slot_free;
  logic             arb_en;
  logic [1:0]       gnt;
  logic             accept;
  logic             sel;

  logic [3:0]       op_fun;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_setcc;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;
  logic [2:0]       alu_flags;

  assign slot_free = !res_valid_q || res_ready;
  assign arb_en    = slot_free && !flush && !reset;

  rr_arbiter2 u_rr (
    .clock (clock),
    .reset (reset),
    .en_i  (arb_en),
    .req_i ({r1_valid, r0_valid}),
    .gnt_o (gnt)
  );

  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];
  assign accept   = |gnt;
  assign sel      = gnt[1];

  assign op_fun   = sel ? r1_fun   : r0_fun;
  assign op_a     = sel ? r1_a     : r0_a;
  assign op_b     = sel ? r1_b     : r0_b;
  assign op_setcc = sel ? r1_setcc : r0_setcc;

  // Operand order is B op A, matching the pipeline's valE = valB op valA.
  always_comb begin
    alu_res = op_b + op_a;
    alu_of  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
    case (decode_fun(op_fun))
      OP_SUB: begin
        alu_res = op_b - op_a;
        alu_of  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_b[WIDTH-1]);
      end
      OP_AND: begin
        alu_res = op_b & op_a;
        alu_of  = 1'b0;
      end
      OP_XOR: begin
        alu_res = op_b ^ op_a;
        alu_of  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    alu_flags        = 3'b000;
    alu_flags[CC_ZF] = (alu_res == '0);
    alu_flags[CC_SF] = alu_res[WIDTH-1];
    alu_flags[CC_OF] = alu_of;
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_val_d   = res_val_q;
    cc_d        = cc_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_id_d    = sel;
      res_val_d   = alu_res;
      if (op_setcc) begin
        cc_d = alu_flags;
      end
    end else if (flush || res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_val_q   <= '0;
      cc_q        <= CC_INIT;
    end else begin
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_val_q   <= res_val_d;
      cc_q        <= cc_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_valE  = res_val_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against a cycle-level
// reference model built from signed arithmetic and a last-winner record.
module tb_alu_arbiter;

  localparam int W = 64;

  logic         clock;
  logic         reset;
  logic         r0_valid, r0_ready, r0_setcc;
  logic [3:0]   r0_fun;
  logic [W-1:0] r0_a, r0_b;
  logic         r1_valid, r1_ready, r1_setcc;
  logic [3:0]   r1_fun;
  logic [W-1:0] r1_a, r1_b;
  logic         flush;
  logic         res_valid, res_ready, res_id;
  logic [W-1:0] res_valE;
  logic [2:0]   cc;

  alu_arbiter #(.WIDTH(W), .CC_INIT(3'b100)) dut (
    .clock     (clock),
    .reset     (reset),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_fun    (r0_fun),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_setcc  (r0_setcc),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_fun    (r1_fun),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_setcc  (r1_setcc),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_valE  (res_valE),
    .cc        (cc)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters / model state ----------------
  int           n_vec  = 0;
  int           n_fail = 0;

  logic         m_valid;
  logic         m_id;
  logic [W-1:0] m_val;
  logic [2:0]   m_cc;
  int           m_last;
  logic [1:0]   m_gnt;

  logic [3:0]   fn;
  logic [W-1:0] ra, rb;
  logic         rsc;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU: overflow means the exact signed result does not fit in W bits.
  task automatic alu_ref(input logic [3:0] f_in, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [2:0] fl);
    logic signed [W+1:0] ea, eb, ex;
    logic ofl;
    ea  = $signed({{2{a[W-1]}}, a});
    eb  = $signed({{2{b[W-1]}}, b});
    ex  = '0;
    ofl = 1'b0;
    case (f_in)
      4'd1: begin
        r   = b - a;
        ex  = eb - ea;
        ofl = (ex != $signed({{2{r[W-1]}}, r}));
      end
      4'd2: r = b & a;
      4'd3: r = b ^ a;
      default: begin
        r   = b + a;
        ex  = eb + ea;
        ofl = (ex != $signed({{2{r[W-1]}}, r}));
      end
    endcase
    fl = {(r == '0), r[W-1], ofl};
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 1'b0;
    m_val   = '0;
    m_cc    = 3'b100;
    m_last  = 1;
    m_gnt   = 2'b00;
  endtask

  function automatic logic [1:0] exp_grant();
    if (reset || flush || (m_valid && !res_ready)) return 2'b00;
    if (r0_valid && r1_valid) return (m_last == 0) ? 2'b10 : 2'b01;
    return {r1_valid, r0_valid};
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic [W-1:0] r;
    logic [2:0]   fl;
    #1;
    m_gnt = exp_grant();
    check("r0_ready", {63'd0, r0_ready}, {63'd0, m_gnt[0]});
    check("r1_ready", {63'd0, r1_ready}, {63'd0, m_gnt[1]});
    check("res_valid", {63'd0, res_valid}, {63'd0, m_valid});
    if (m_valid) begin
      check("res_id", {63'd0, res_id}, {63'd0, m_id});
      check("res_valE", res_valE, m_val);
    end
    check("cc", {61'd0, cc}, {61'd0, m_cc});
    @(posedge clock);
    if (m_gnt[0]) begin
      alu_ref(r0_fun, r0_a, r0_b, r, fl);
      m_valid = 1'b1; m_id = 1'b0; m_val = r; m_last = 0;
      if (r0_setcc) m_cc = fl;
    end else if (m_gnt[1]) begin
      alu_ref(r1_fun, r1_a, r1_b, r, fl);
      m_valid = 1'b1; m_id = 1'b1; m_val = r; m_last = 1;
      if (r1_setcc) m_cc = fl;
    end else if (flush || res_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clock);
  endtask

  // ---------------- drivers ----------------
  task automatic drive0(input logic v, input logic [3:0] f_in, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sc);
    r0_valid = v; r0_fun = f_in; r0_a = a; r0_b = b; r0_setcc = sc;
  endtask

  task automatic drive1(input logic v, input logic [3:0] f_in, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sc);
    r1_valid = v; r1_fun = f_in; r1_a = a; r1_b = b; r1_setcc = sc;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_op();
    fn  = 4'($urandom_range(0, 5));
    ra  = rand_operand();
    rb  = rand_operand();
    rsc = 1'($urandom_range(0, 1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    flush     = 1'b0;
    res_ready = 1'b0;
    drive0(1'b1, 4'd1, 64'd5, 64'd3, 1'b1);
    drive1(1'b0, 4'd0, '0, '0, 1'b0);
    model_reset();

    // Reset values and no ready while reset is high.
    reset = 1'b1;
    #2;
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_id", {63'd0, res_id}, 64'd0);
    check("rst_res_valE", res_valE, 64'd0);
    check("rst_cc", {61'd0, cc}, 64'd4);
    check("rst_r0_ready", {63'd0, r0_ready}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // r0 sub: 3 - 5.
    res_ready = 1'b1;
    tick();
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    #1;
    check("sub_val", res_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_id", {63'd0, res_id}, 64'd0);
    check("sub_cc", {61'd0, cc}, 64'd2);
    tick();

    // Single r1 op, leaving r1 as last winner so the tie sequence starts at r0.
    drive1(1'b1, 4'd2, rand_operand(), rand_operand(), 1'b0);
    tick();
    drive1(1'b0, 4'd0, '0, '0, 1'b0);

    // Both valid for four cycles: grants alternate 0,1,0,1.
    rand_op(); drive0(1'b1, fn, ra, rb, rsc);
    rand_op(); drive1(1'b1, fn, ra, rb, rsc);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_seq", {63'd0, r0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      tick();
      rand_op();
      if (m_gnt[0]) drive0(1'b1, fn, ra, rb, rsc);
      else          drive1(1'b1, fn, ra, rb, rsc);
    end
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    drive1(1'b0, 4'd0, '0, '0, 1'b0);
    tick();

    // Backpressure: held result, r1 waits, then accepted as the slot frees.
    res_ready = 1'b0;
    rand_op(); drive0(1'b1, fn, ra, rb, rsc);
    tick();
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    rand_op(); drive1(1'b1, fn, ra, rb, rsc);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_r1_ready", {63'd0, r1_ready}, 64'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_accept", {63'd0, r1_ready}, 64'd1);
    tick();
    drive1(1'b0, 4'd0, '0, '0, 1'b0);
    tick();

    // Overflow on add, then the same add with setcc=0 after cc was set to ZF.
    drive0(1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    tick();
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    #1;
    check("ovf_val", res_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("ovf_cc", {61'd0, cc}, 64'd3);
    tick();
    drive0(1'b1, 4'd3, 64'h1234, 64'h1234, 1'b1);
    tick();
    drive0(1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    tick();
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    #1;
    check("nocc_cc", {61'd0, cc}, 64'd4);
    tick();

    // Flush with a held result and r0 waiting.
    res_ready = 1'b0;
    rand_op(); drive0(1'b1, fn, ra, rb, 1'b1);
    tick();
    rand_op(); drive0(1'b1, fn, ra, rb, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_r0_ready", {63'd0, r0_ready}, 64'd0);
    tick();
    flush = 1'b0;
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    #1;
    check("flush_res_valid", {63'd0, res_valid}, 64'd0);
    tick();
    rand_op(); drive0(1'b1, fn, ra, rb, rsc);
    rand_op(); drive1(1'b1, fn, ra, rb, rsc);
    tick();

    // Randomized traffic; a requester holds its op until the model grants it.
    for (int n = 0; n < 400; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      if (!r0_valid || m_gnt[0]) begin
        rand_op();
        drive0($urandom_range(0, 3) != 0, fn, ra, rb, rsc);
      end
      if (!r1_valid || m_gnt[1]) begin
        rand_op();
        drive1($urandom_range(0, 3) != 0, fn, ra, rb, rsc);
      end
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset while a result is held.
    res_ready = 1'b0;
    drive1(1'b0, 4'd0, '0, '0, 1'b0);
    rand_op(); drive0(1'b1, fn, ra, rb, 1'b1);
    tick();
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_res_valid", {63'd0, res_valid}, 64'd0);
    check("arst_cc", {61'd0, cc}, 64'd4);
    check("arst_res_id", {63'd0, res_id}, 64'd0);
    check("arst_res_valE", res_valE, 64'd0);
    model_reset();
    @(negedge clock);
    reset     = 1'b0;
    res_ready = 1'b1;
    rand_op(); drive0(1'b1, fn, ra, rb, rsc);
    rand_op(); drive1(1'b1, fn, ra, rb, rsc);
    #1;
    check("arst_first_tie", {63'd0, r0_ready}, 64'd1);
    tick();
    drive0(1'b0, 4'd0, '0, '0, 1'b0);
    tick();
    drive1(1'b0, 4'd0, '0, '0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
